// File: rtl/vrc7_snd_wr_sched.sv
// VRC7 FM-sound write scheduler. It queues CPU address/data writes, paces them to the OPLL
// minimum write spacing, and gives save-state restore writes priority on the shared port.
module vrc7_snd_wr_sched #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYC    = 42,
  parameter int unsigned AW         = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_we,
  input  logic          cpu_sel,
  input  logic [7:0]    cpu_dat,
  input  logic          ss_req,
  input  logic [AW-1:0] ss_addr,
  input  logic [7:0]    ss_dat,
  output logic          ss_ack,
  output logic          opll_we,
  output logic [AW-1:0] opll_addr,
  output logic [7:0]    opll_dat,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic          idle
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e          state_q;
  logic [TW-1:0]   timer_q;
  logic            src_ss_q;
  logic            opll_we_q;
  logic            ss_ack_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      dat_q;
  logic            ovf_q;
  logic [AW-1:0]   latch_q;

  logic [AW+7:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   cnt_q;

  logic            push_req;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic [AW+7:0]   head;

  always_comb begin
    push_req = cpu_we && cpu_sel;
    full     = (cnt_q == CW'(FIFO_DEPTH));
    pop      = (state_q == StIssue) && !src_ss_q;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    head     = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {latch_q, cpu_dat};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      latch_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (cpu_we && !cpu_sel) begin
        latch_q <= cpu_dat[AW-1:0];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      src_ss_q  <= 1'b0;
      opll_we_q <= 1'b0;
      ss_ack_q  <= 1'b0;
      addr_q    <= '0;
      dat_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ss_req) begin
            state_q   <= StIssue;
            src_ss_q  <= 1'b1;
            opll_we_q <= 1'b1;
            ss_ack_q  <= 1'b1;
            addr_q    <= ss_addr;
            dat_q     <= ss_dat;
          end else if (cnt_q != '0) begin
            state_q   <= StIssue;
            src_ss_q  <= 1'b0;
            opll_we_q <= 1'b1;
            addr_q    <= head[AW+7:8];
            dat_q     <= head[7:0];
          end
        end
        StIssue: begin
          opll_we_q <= 1'b0;
          ss_ack_q  <= 1'b0;
          timer_q   <= TW'(GAP_CYC - 1);
          state_q   <= StGap;
        end
        StGap: begin
          // Leaving as the count reaches zero makes the pulse pitch GAP_CYC+1 under load.
          timer_q <= timer_q - TW'(1);
          if (timer_q == TW'(1)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    opll_we   = opll_we_q;
    ss_ack    = ss_ack_q;
    opll_addr = addr_q;
    opll_dat  = dat_q;
    ovf       = ovf_q;
    idle      = (state_q == StIdle) && (cnt_q == '0) && !ss_req;
  end

endmodule

// File: tb/tb_vrc7_snd_wr_sched.sv
// Self-checking bench for vrc7_snd_wr_sched: directed scenarios plus random traffic, all
// checked every cycle against a cycle-count based reference model.
module tb_vrc7_snd_wr_sched;
  localparam int DEPTH = 4;
  localparam int GAP   = 42;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_we = 1'b0;
  logic          cpu_sel = 1'b0;
  logic [7:0]    cpu_dat = '0;
  logic          ss_req = 1'b0;
  logic [AW-1:0] ss_addr = '0;
  logic [7:0]    ss_dat = '0;
  logic          ss_ack;
  logic          opll_we;
  logic [AW-1:0] opll_addr;
  logic [7:0]    opll_dat;
  logic          ovf;
  logic          ovf_clr = 1'b0;
  logic          idle;

  vrc7_snd_wr_sched #(.FIFO_DEPTH(DEPTH), .GAP_CYC(GAP), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_dat(cpu_dat),
    .ss_req(ss_req), .ss_addr(ss_addr), .ss_dat(ss_dat), .ss_ack(ss_ack),
    .opll_we(opll_we), .opll_addr(opll_addr), .opll_dat(opll_dat), .ovf(ovf),
    .ovf_clr(ovf_clr), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: issue timing expressed as absolute cycle numbers.
  int               cyc = 0;
  int               ready_at = 0;
  int               issue_at = -1;
  bit               iss_ss;
  logic [AW+7:0]    iss_word;
  logic [AW+7:0]    mq[$];
  logic [AW-1:0]    m_latch;
  bit               m_ovf;
  bit               chk_en = 0;
  bit               last_ack_m = 0;

  typedef struct {int c; logic [AW-1:0] a; logic [7:0] d; bit ss;} pulse_t;
  pulse_t plog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle();
    bit in_issue, in_idle, ovfl;
    pulse_t p;
    in_issue = (issue_at == cyc);
    in_idle  = !in_issue && (cyc >= ready_at);
    if (chk_en) begin
      chk("opll_we", 32'(opll_we), 32'(in_issue));
      chk("ss_ack", 32'(ss_ack), 32'(in_issue && iss_ss));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("idle", 32'(idle), 32'(in_idle && mq.size() == 0 && !ss_req));
      if (in_issue) begin
        chk("opll_addr", 32'(opll_addr), 32'(iss_word[AW+7:8]));
        chk("opll_dat", 32'(opll_dat), 32'(iss_word[7:0]));
      end
      if (opll_we === 1'b1) begin
        p.c = cyc; p.a = opll_addr; p.d = opll_dat; p.ss = (ss_ack === 1'b1);
        plog.push_back(p);
      end
    end
    last_ack_m = in_issue && iss_ss;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_latch  = '0;
      m_ovf    = 0;
      issue_at = -1;
      ready_at = cyc + 1;
    end else begin
      ovfl = 0;
      if (in_issue) ready_at = cyc + GAP;
      if (in_idle && (ss_req || mq.size() > 0)) begin
        issue_at = cyc + 1;
        iss_ss   = ss_req;
        iss_word = ss_req ? {ss_addr, ss_dat} : mq[0];
      end
      if (in_issue && !iss_ss) void'(mq.pop_front());
      if (cpu_we && cpu_sel) begin
        if (mq.size() < DEPTH) mq.push_back({m_latch, cpu_dat});
        else ovfl = 1;
      end else if (cpu_we) begin
        m_latch = cpu_dat[AW-1:0];
      end
      if (ovfl) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      // Requester drops ss_req the cycle after it sees the acknowledge.
      if (last_ack_m) ss_req = 0;
      cycle();
    end
  endtask

  task automatic wr(input bit sel, input logic [7:0] d);
    cpu_we = 1; cpu_sel = sel; cpu_dat = d;
    cycle();
    cpu_we = 0; cpu_sel = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; ss_req = 0; cpu_we = 0; ovf_clr = 0;
    cycle();
    rst_n = 1;
    chk("rst_addr", 32'(opll_addr), 32'h0);
    chk("rst_dat", 32'(opll_dat), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    chk("rst_ovf", 32'(ovf), 32'h0);
    plog.delete();
  endtask

  initial begin
    int wc, nss;
    logic [7:0] exp_d [3];
    // Initial reset before any checking: DUT state is unknown until it completes.
    cycle();
    chk_en = 1;

    // 1: single write latency and address/data
    do_reset();
    wr(0, 8'h10);
    wc = cyc;
    wr(1, 8'hA5);
    run(60);
    chk("t1_cnt", 32'(plog.size()), 32'd1);
    if (plog.size() >= 1) begin
      chk("t1_lat", 32'(plog[0].c - wc), 32'd2);
      chk("t1_addr", 32'(plog[0].a), 32'h10);
      chk("t1_dat", 32'(plog[0].d), 32'hA5);
    end

    // 2: back-to-back data writes reuse the latch, spaced GAP+1
    do_reset();
    wr(0, 8'h30);
    wr(1, 8'h01); wr(1, 8'h02); wr(1, 8'h03);
    run(150);
    chk("t2_cnt", 32'(plog.size()), 32'd3);
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03;
    for (int i = 0; i < 3 && i < plog.size(); i++) begin
      chk("t2_addr", 32'(plog[i].a), 32'h30);
      chk("t2_dat", 32'(plog[i].d), 32'(exp_d[i]));
      if (i > 0) chk("t2_gap", 32'(plog[i].c - plog[i-1].c), 32'(GAP + 1));
    end

    // 3: overflow, sticky ovf, clear
    do_reset();
    wr(0, 8'h08);
    for (int i = 0; i < 6; i++) wr(1, 8'(8'h40 + i));
    run(5);
    chk("t3_ovf", 32'(ovf), 32'h1);
    run(250);
    chk("t3_cnt", 32'(plog.size()), 32'd5);
    ovf_clr = 1; cycle(); ovf_clr = 0;
    chk("t3_clr", 32'(ovf), 32'h0);

    // 4: ss_req during GAP jumps ahead of queued writes
    do_reset();
    wr(0, 8'h11);
    wr(1, 8'hB0); wr(1, 8'hB1); wr(1, 8'hB2);
    run(5);
    ss_req = 1; ss_addr = 6'h20; ss_dat = 8'h7F;
    run(200);
    chk("t4_cnt", 32'(plog.size()), 32'd4);
    nss = 0;
    foreach (plog[i]) if (plog[i].ss) nss++;
    chk("t4_nss", 32'(nss), 32'd1);
    if (plog.size() == 4) begin
      chk("t4_ss_pos", 32'(plog[1].ss), 32'h1);
      chk("t4_ss_addr", 32'(plog[1].a), 32'h20);
      chk("t4_ss_dat", 32'(plog[1].d), 32'h7F);
      chk("t4_q1", 32'(plog[2].d), 32'hB1);
      chk("t4_q2", 32'(plog[3].d), 32'hB2);
    end

    // 5: reset discards queued writes mid-gap
    do_reset();
    wr(0, 8'h02);
    for (int i = 0; i < 4; i++) wr(1, 8'(8'h60 + i));
    run(3);
    do_reset();
    run(120);
    chk("t5_none", 32'(plog.size()), 32'd0);

    // 6: upper address bits ignored
    do_reset();
    wr(0, 8'hC5);
    wr(1, 8'h33);
    run(50);
    chk("t6_cnt", 32'(plog.size()), 32'd1);
    if (plog.size() >= 1) chk("t6_addr", 32'(plog[0].a), 32'h05);

    // Random traffic including ss aborts, overflow clears and occasional resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cpu_we  = ($urandom_range(0, 5) == 0);
      cpu_sel = ($urandom_range(0, 3) != 0);
      cpu_dat = 8'($urandom);
      ovf_clr = ($urandom_range(0, 60) == 0);
      if (last_ack_m) ss_req = 0;
      else if (!ss_req && $urandom_range(0, 80) == 0) begin
        ss_req = 1; ss_addr = AW'($urandom); ss_dat = 8'($urandom);
      end else if (ss_req && $urandom_range(0, 150) == 0) ss_req = 0;
      rst_n = ($urandom_range(0, 1500) != 0);
      cycle();
      rst_n = 1;
    end
    cpu_we = 0; ovf_clr = 0; ss_req = 0;
    run(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
